// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_START_DEF = 64'h0000_0000_8000_0000;
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;

    typedef logic [XLEN-1:0]    addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // One fetch-buffer entry: the returned word and the PC it was fetched from.
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    function automatic addr_t align_pc(input addr_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: power-of-two ring of {instr, pc} entries with push/pop/flush and an occupancy count.
module ifu_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, request credits, wrong-path drop counter and fetch buffer feeding decode.
// Optional IFU_MISALIGN_CHK_EN: a misaligned redirect target raises o_fetch_misalign and halts fetch until reset.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [63:0] PC_START        = PC_START_DEF,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] o_instr,
    output logic [63:0] o_instr_addr,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_branch_jump,
    input  logic [63:0] i_next_pc,
    output logic        o_if_req,
    output logic [63:0] o_if_addr,
    input  logic        i_if_req_ready,
    input  logic        i_if_resp_valid,
    input  logic [31:0] i_if_resp_data,
    output logic        o_fetch_misalign
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);

    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

    addr_t         pc_q, pc_d;
    addr_t         resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    fetch_entry_t   head, wdata;
    logic [FCW-1:0] count;
    logic           head_valid, consume, redirect, accept, push, misalign_hold;
    addr_t          target;

    assign head_valid = (count != '0);
    assign consume    = head_valid & ~i_stall;
    assign redirect   = i_branch_jump & consume;

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clock) begin
        if (reset)                                       misalign_q <= 1'b0;
        else if (redirect && (i_next_pc[1:0] != 2'b00)) misalign_q <= 1'b1;
    end

    assign misalign_hold = misalign_q;
    assign target        = i_next_pc;
`else
    assign misalign_hold = 1'b0;
    assign target        = align_pc(i_next_pc);
`endif

    // Credits cover both in-flight requests and buffered words, so a response can always be pushed.
    assign o_if_req = ~reset & ~redirect & ~misalign_hold & (inflight_q < MAX_OUT)
                    & ((SW'(inflight_q) + SW'(count)) < DEPTH_S);
    assign o_if_addr = pc_q;
    assign accept    = o_if_req & i_if_req_ready;
    assign push      = i_if_resp_valid & (drop_q == '0) & ~redirect;
    assign wdata     = '{instr: i_if_resp_data, pc: resp_pc_q};

    // NOTE: every next-state variable gets its hold value first so this block can never infer a latch.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(accept) - CW'(i_if_resp_valid);
        if (accept) pc_d = pc_q + 64'd4;
        if (push)   resp_pc_d = resp_pc_q + 64'd4;
        if (i_if_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
        // A response landing in the redirect cycle is wrong-path too, so it is excluded from the drop count.
        if (redirect) begin
            pc_d      = target;
            resp_pc_d = target;
            drop_d    = inflight_q - CW'(i_if_resp_valid);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= PC_START;
            resp_pc_q  <= PC_START;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (consume),
        .flush_i (redirect),
        .wdata_i (wdata),
        .head_o  (head),
        .count_o (count)
    );

    assign o_valid          = head_valid;
    assign o_instr          = head_valid ? head.instr : BUBBLE_INSTR;
    assign o_instr_addr     = head_valid ? head.pc : '0;
    assign o_fetch_misalign = misalign_hold;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: in-order memory model with random latency plus a sequential-stream reference.
module tb_ifu_fetch;

    localparam logic [63:0] PC0  = 64'h0000_0000_8000_0000;
    localparam int          MAXO = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] o_instr;
    logic [63:0] o_instr_addr;
    logic        o_valid;
    logic        i_stall;
    logic        i_branch_jump;
    logic [63:0] i_next_pc;
    logic        o_if_req;
    logic [63:0] o_if_addr;
    logic        i_if_req_ready;
    logic        i_if_resp_valid;
    logic [31:0] i_if_resp_data;
    logic        o_fetch_misalign;

    always #5 clock = ~clock;

    ifu_fetch dut (
        .clock            (clock),
        .reset            (reset),
        .o_instr          (o_instr),
        .o_instr_addr     (o_instr_addr),
        .o_valid          (o_valid),
        .i_stall          (i_stall),
        .i_branch_jump    (i_branch_jump),
        .i_next_pc        (i_next_pc),
        .o_if_req         (o_if_req),
        .o_if_addr        (o_if_addr),
        .i_if_req_ready   (i_if_req_ready),
        .i_if_resp_valid  (i_if_resp_valid),
        .i_if_resp_data   (i_if_resp_data),
        .o_fetch_misalign (o_fetch_misalign)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          cyc, last_due;
    int          vectors, miscompares, consumed;
    logic [63:0] exp_pc, exp_req;
    bit          exp_mis;
    bit          s_valid, s_req, s_mis;
    logic [63:0] s_iaddr, s_if_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return ((a[31:0] ^ a[63:32]) * 32'h9E37_79B1) + 32'h1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        i_stall = 1'b0; i_branch_jump = 1'b0; i_next_pc = '0;
        i_if_req_ready = 1'b0; i_if_resp_valid = 1'b0; i_if_resp_data = '0;
        @(negedge clock);
        check("rst_valid", o_valid, 0);
        check("rst_instr", o_instr, 0);
        check("rst_iaddr", o_instr_addr, 0);
        check("rst_req",   o_if_req, 0);
        check("rst_mis",   o_fetch_misalign, 0);
        pend.delete();
        cyc = 0; last_due = -1;
        exp_pc = PC0; exp_req = PC0; exp_mis = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check settled outputs, then advance the models.
    task automatic step(input bit stall, input bit br, input logic [63:0] tgt, input bit rdy,
                        input int lat_lo, input int lat_hi);
        bit          resp, redir, accept;
        int          due;
        logic [63:0] tgt_al;
        @(negedge clock);
        reset = 1'b0;
        i_stall = stall; i_branch_jump = br; i_next_pc = tgt; i_if_req_ready = rdy;
        resp = (pend.size() > 0) && (pend[0].due <= cyc);
        i_if_resp_valid = resp;
        i_if_resp_data  = resp ? mem_word(pend[0].addr) : $urandom;
        #1;
        s_valid = o_valid; s_req = o_if_req; s_mis = o_fetch_misalign;
        s_iaddr = o_instr_addr; s_if_addr = o_if_addr;
        tgt_al = tgt & ~64'h3;
        if (!o_valid) begin
            check("bubble_instr", o_instr, 0);
            check("bubble_addr",  o_instr_addr, 0);
        end else begin
            check("instr_addr", o_instr_addr, exp_pc);
            check("instr_data", o_instr, mem_word(exp_pc));
        end
        redir = br && o_valid && !stall;
        if (redir)   check("req_in_redirect", o_if_req, 0);
        if (exp_mis) check("req_while_mis", o_if_req, 0);
        if (exp_mis) check("valid_while_mis", o_valid, 0);
        check("misalign", o_fetch_misalign, exp_mis);
        if (o_if_req) check("req_addr", o_if_addr, exp_req);
        accept = o_if_req && rdy;
        if (accept) check("credit", pend.size() < MAXO, 1);
        if (resp) void'(pend.pop_front());
        if (accept) begin
            due = cyc + $urandom_range(lat_lo, lat_hi);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: o_if_addr, due: due});
            exp_req = exp_req + 64'd4;
        end
        if (o_valid && !stall) begin
            consumed++;
            exp_pc = redir ? tgt_al : exp_pc + 64'd4;
        end
        if (redir) begin
            exp_req = tgt_al;
`ifdef IFU_MISALIGN_CHK_EN
            if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
`endif
        end
        cyc++;
    endtask

    // Runs unstalled until the head seen for the coming cycle matches; leaves time just before that cycle's drive.
    task automatic run_to_head(input logic [63:0] a, input bit any_addr, input bit need_resp,
                               input int lat, input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step(1'b0, 1'b0, '0, 1'b1, lat, lat);
            @(posedge clock); #1;
            found = o_valid && (any_addr || o_instr_addr == a)
                 && (!need_resp || (pend.size() > 0 && pend[0].due <= cyc));
        end
        check({tag, "_reached"}, found, 1);
    endtask

    task automatic next_valid(input logic [63:0] a, input int lat, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step(1'b0, 1'b0, '0, 1'b1, lat, lat);
            seen = s_valid;
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_addr"}, s_iaddr, a);
    endtask

    initial begin
        logic [63:0] head0, tgt;
        vectors = 0; miscompares = 0; consumed = 0;
        reset = 1'b1;

        // Cold start: request at cycle 0, one-cycle memory, first instruction visible at cycle 2.
        do_reset();
        step(0, 0, '0, 1, 1, 1);
        check("t1_req_c0",  s_req, 1);
        check("t1_addr_c0", s_if_addr, PC0);
        step(0, 0, '0, 1, 1, 1);
        check("t1_novalid_c1", s_valid, 0);
        check("t1_addr_c1",    s_if_addr, PC0 + 64'd4);
        step(0, 0, '0, 1, 1, 1);
        check("t1_valid_c2", s_valid, 1);
        check("t1_iaddr_c2", s_iaddr, PC0);
        repeat (6) step(0, 0, '0, 1, 1, 1);

        // Stall for three cycles: head frozen, fetch throttled once the buffer fills, then resumes in order.
        run_to_head('0, 1, 0, 1, "t2");
        step(1, 0, '0, 1, 1, 1);
        head0 = s_iaddr;
        check("t2_valid", s_valid, 1);
        step(1, 0, '0, 1, 1, 1);
        check("t2_hold1", s_iaddr, head0);
        step(1, 0, '0, 1, 1, 1);
        check("t2_hold2", s_iaddr, head0);
        check("t2_noreq_full", s_req, 0);
        next_valid(head0, 1, "t2_resume");
        next_valid(head0 + 64'd4, 1, "t2_next");

        // Branch from 8000_0008 with two-cycle memory: wrong-path words dropped.
        do_reset();
        run_to_head(PC0 + 64'd8, 0, 0, 2, "t3");
        step(0, 1, 64'h8000_0100, 1, 2, 2);
        next_valid(64'h8000_0100, 2, "t3_target");

        // Redirect in the same cycle a response arrives.
        do_reset();
        run_to_head('0, 1, 1, 1, "t4");
        step(0, 1, 64'h8000_0400, 1, 1, 1);
        step(0, 0, '0, 1, 1, 1);
        check("t4_req_r1",  s_req, 1);
        check("t4_addr_r1", s_if_addr, 64'h8000_0400);
        next_valid(64'h8000_0400, 1, "t4_target");

        // Stall overrides a branch; the redirect is taken once the stall drops.
        do_reset();
        run_to_head('0, 1, 0, 1, "t5");
        step(1, 1, 64'h8000_0200, 1, 1, 1);
        head0 = s_iaddr;
        step(1, 1, 64'h8000_0200, 1, 1, 1);
        check("t5_valid_held", s_valid, 1);
        check("t5_head_held",  s_iaddr, head0);
        step(0, 1, 64'h8000_0200, 1, 1, 1);
        next_valid(64'h8000_0200, 1, "t5_target");

        // Misaligned redirect target.
        do_reset();
        run_to_head('0, 1, 0, 1, "t6");
        step(0, 1, 64'h8000_0102, 1, 1, 1);
        step(0, 0, '0, 1, 1, 1);
`ifdef IFU_MISALIGN_CHK_EN
        check("t6_mis_flag", s_mis, 1);
        check("t6_no_req",   s_req, 0);
        repeat (4) step(0, 0, '0, 1, 1, 1);
        check("t6_mis_sticky", s_mis, 1);
        check("t6_no_valid",   s_valid, 0);
`else
        check("t6_no_flag", s_mis, 0);
        check("t6_req",     s_req, 1);
        check("t6_addr",    s_if_addr, 64'h8000_0100);
        next_valid(64'h8000_0100, 1, "t6_target");
`endif

        // Random traffic: stalls, branches, backpressure and variable memory latency.
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                case ($urandom_range(0, 7))
                    0:       tgt = {$urandom, $urandom} & ~64'h3;
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                    default: tgt = PC0 + 64'($urandom_range(0, 255)) * 64'd4;
                endcase
`ifndef IFU_MISALIGN_CHK_EN
                if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
                step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt,
                     $urandom_range(0, 3) != 0, 1, 1 + seg % 3);
            end
        end
        check("progress", consumed > 200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
